// File: rtl/layer_seq_mac.sv
// layer_seq_mac: dense fixed-point layer y[o] = sat(b[o] + sum_i x[i]*w[o][i]) on one shared time-multiplexed MAC.
//   clk/rst : rising-edge clock, synchronous active-high reset
//   start   : run request, sampled only in IDLE; x/w/b are captured on that edge
//   x, w, b : packed signed inputs, x[i] at [i*DW], w[o][i] at [(o*N_IN+i)*DW], b[o] at [o*DW]
//   y       : registered outputs, all updated together at the end of a run
//   busy    : run in progress; done: one-cycle completion pulse; sat: last run clamped an output
//   Optional LAYER_SEQ_RELU_EN applies ReLU after the clamp (sat still reports the clamp).
module layer_seq_mac #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_IN*DW-1:0]       x,
  input  logic [N_OUT*N_IN*DW-1:0] w,
  input  logic [N_OUT*DW-1:0]      b,
  output logic [N_OUT*DW-1:0]      y,
  output logic                     busy,
  output logic                     done,
  output logic                     sat
);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int OW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  state_t state, nxt;
  logic [N_IN*DW-1:0] xr;
  logic [N_OUT*N_IN*DW-1:0] wr;
  logic [N_OUT*DW-1:0] br, y_work, y_fin;
  logic [IW-1:0] i;
  logic [OW-1:0] o;
  logic signed [ACC_W-1:0] acc, r;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0] yv;
  logic clamp, sat_work, last_i, last_o;
  // bias is pre-scaled into the accumulator's 2*FRAC fraction domain
  function automatic logic signed [ACC_W-1:0] bias(input logic [DW-1:0] v);
    return {{(ACC_W-DW){v[DW-1]}}, v} <<< FRAC;
  endfunction
  assign last_i = i == IW'(N_IN - 1);
  assign last_o = o == OW'(N_OUT - 1);
  assign prod = $signed(xr[i*DW +: DW]) * $signed(wr[(o*N_IN+i)*DW +: DW]);
  assign r = acc >>> FRAC;
  assign clamp = r > YMAX || r < YMIN;
  always_comb begin
    yv = r > YMAX ? YMAX[DW-1:0] : r < YMIN ? YMIN[DW-1:0] : r[DW-1:0];
`ifdef LAYER_SEQ_RELU_EN
    yv = yv[DW-1] ? '0 : yv;
`endif
    y_fin = y_work;
    y_fin[o*DW +: DW] = yv;
  end
  always_comb
    nxt = state == IDLE ? (start ? MAC : IDLE) :
          state == MAC  ? (last_i ? WB : MAC) :
          state == WB   ? (last_o ? DONE : MAC) : IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // outputs are published on the final WB edge so y/sat are valid while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      xr <= '0;
      wr <= '0;
      br <= '0;
      y_work <= '0;
      y <= '0;
      acc <= '0;
      i <= '0;
      o <= '0;
      sat_work <= 1'b0;
      sat <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == WB && last_o;
      if (state == IDLE && start) begin
        xr <= x;
        wr <= w;
        br <= b;
        i <= '0;
        o <= '0;
        acc <= bias(b[DW-1:0]);
        sat_work <= 1'b0;
        busy <= 1'b1;
      end
      if (state == MAC) begin
        acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        if (!last_i) i <= i + 1'b1;
      end
      if (state == WB) begin
        y_work <= y_fin;
        sat_work <= sat_work | clamp;
        if (last_o) begin
          y <= y_fin;
          sat <= sat_work | clamp;
          busy <= 1'b0;
        end else begin
          o <= o + 1'b1;
          i <= '0;
          acc <= bias(br[(o+1)*DW +: DW]);
        end
      end
    end
  end
endmodule

// File: tb/tb_layer_seq_mac.sv
// tb_layer_seq_mac: directed checks of layer_seq_mac (defaults) plus a wide-parameter instance against a real-valued model.
module tb_layer_seq_mac;
`ifdef LAYER_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, start1 = 0;
  logic [31:0] x;
  logic [63:0] w;
  logic [31:0] b, y;
  logic busy, done, sat;
  logic [71:0] x1;
  logic [287:0] w1;
  logic [95:0] b1, y1;
  logic busy1, done1, sat1;
  int n_tests = 0, n_fail = 0;
  int lat, nd, nb;
  always #5 clk = ~clk;
  layer_seq_mac dut (.clk(clk), .rst(rst), .start(start), .x(x), .w(w), .b(b), .y(y), .busy(busy), .done(done), .sat(sat));
  layer_seq_mac #(.N_IN(3), .N_OUT(4), .DW(24), .FRAC(12), .ACC_W(56)) dut1 (.clk(clk), .rst(rst), .start(start1), .x(x1), .w(w1), .b(b1), .y(y1), .busy(busy1), .done(done1), .sat(sat1));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // runs one job on dut; restart_at / rst_at name the edge at which a stray start / reset is sampled (0 = none)
  task automatic run(input logic [31:0] xv, input logic [63:0] wv, input logic [31:0] bv, input int restart_at, input int rst_at);
    @(negedge clk);
    x = xv; w = wv; b = bv; start = 1;
    @(negedge clk);
    start = 0;
    x = 32'h5555_5555;
    lat = 0; nd = 0; nb = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      if (k - 1 == restart_at - 1) begin start = 1; x = 32'h0700_0300; end
      if (k - 1 == restart_at) start = 0;
      if (k - 1 == rst_at - 1) rst = 1;
      if (k - 1 == rst_at) rst = 0;
      @(negedge clk);
      if (done) begin nd++; if (lat == 0) lat = k; end
      if (busy) nb++;
    end
    start = 0; rst = 0;
  endtask
  localparam logic [31:0] XB = {16'h0200, 16'h0100};
  localparam logic [63:0] WB = {16'h0040, 16'hFF00, 16'h00C0, 16'h0080};
  localparam logic [31:0] BB = {16'h0000, 16'h0040};
  initial begin
    x = '0; w = '0; b = '0; x1 = '0; w1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset_y", y, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sat", sat, 0);
    check("reset_y1", y1, 0);
    run(XB, WB, BB, 0, 0);
    check("basic_lat", lat, 6);
    check("basic_ndone", nd, 1);
    check("basic_busy", nb, 6);
    check("basic_y0", y[15:0], 16'h0240);
    check("basic_y1", y[31:16], RELU ? 16'h0000 : 16'hFF80);
    check("basic_sat", sat, 0);
    run({16'h7F00, 16'h7F00}, {16'hFF00, 16'hFF00, 16'h0100, 16'h0100}, 32'h0, 0, 0);
    check("sat_y0", y[15:0], 16'h7FFF);
    check("sat_y1", y[31:16], RELU ? 16'h0000 : 16'h8000);
    check("sat_flag", sat, 1);
    check("sat_lat", lat, 6);
    run(XB, WB, BB, 0, 3);
    check("rst_ndone", nd, 0);
    check("rst_y", y, 0);
    check("rst_sat", sat, 0);
    check("rst_busy", busy, 0);
    run({16'h7F00, 16'h7F00}, {16'hFF00, 16'hFF00, 16'h0100, 16'h0100}, 32'h0, 0, 0);
    run(XB, WB, BB, 0, 0);
    check("clr_sat", sat, 0);
    check("after_rst_y0", y[15:0], 16'h0240);
    check("after_rst_y1", y[31:16], RELU ? 16'h0000 : 16'hFF80);
    run({16'h0000, 16'h0001}, {16'h0000, 16'hFF80, 16'h0000, 16'h0080}, 32'h0, 0, 0);
    check("trunc_y0", y[15:0], 16'h0000);
    check("trunc_y1", y[31:16], RELU ? 16'h0000 : 16'hFFFF);
    run(XB, WB, BB, 2, 0);
    check("restart_ndone", nd, 1);
    check("restart_busy", nb, 6);
    check("restart_y0", y[15:0], 16'h0240);
    check("restart_y1", y[31:16], RELU ? 16'h0000 : 16'hFF80);
    check("restart_idle", busy, 0);
    for (int r = 0; r < 3; r++) begin
      int xv[3], wv[4][3], bv[4], e;
      real v;
      bit es;
      es = 0;
      for (int i = 0; i < 3; i++) begin
        xv[i] = int'($urandom) >>> (8 + 6 * r);
        x1[i*24 +: 24] = xv[i][23:0];
      end
      for (int o = 0; o < 4; o++) begin
        bv[o] = int'($urandom) >>> 8;
        b1[o*24 +: 24] = bv[o][23:0];
        for (int i = 0; i < 3; i++) begin
          wv[o][i] = int'($urandom) >>> 8;
          w1[(o*3+i)*24 +: 24] = wv[o][i][23:0];
        end
      end
      @(negedge clk) start1 = 1;
      @(negedge clk) start1 = 0;
      lat = 0;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
        @(negedge clk);
        if (done1) lat = k;
      end
      check("sweep_lat", lat, 16);
      for (int o = 0; o < 4; o++) begin
        v = real'(bv[o]);
        for (int i = 0; i < 3; i++) v = v + real'(xv[i]) * real'(wv[o][i]) / 4096.0;
        v = $floor(v);
        if (v > 8388607.0) begin v = 8388607.0; es = 1; end
        if (v < -8388608.0) begin v = -8388608.0; es = 1; end
        if (RELU && v < 0.0) v = 0.0;
        e = int'(v);
        check($sformatf("sweep%0d_y%0d", r, o), y1[o*24 +: 24], e[23:0]);
      end
      check("sweep_sat", sat1, es);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
